// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response bus between fetch_queue (master) and imem (slave).
// One request outstanding at a time; req/addr held until ack.
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding IF/ID: owns fetch PC, one outstanding imem request, FIFO of {pc4, inst}.
// Optional FETCH_QUEUE_BYPASS_EN: an ack into an empty queue is presented on inst the same cycle.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       deq,
  fetch_queue_if.master              imem,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [31:0]    fpc_q, fpc_d, target_q, target_d, fpc_inc;
  logic [PW-1:0]  rptr_q, wptr_q;
  logic [CW-1:0]  count_q;
  logic [31:0]    inst_mem [DEPTH];
  logic [31:0]    pc4_mem  [DEPTH];
  logic           fifo_valid, ack_hit, accept, wr_en, rd_en;

  assign fpc_inc    = fpc_q + 32'd4;
  assign fifo_valid = (count_q != '0);
  assign count      = count_q;

  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = fpc_q;
    state_d        = state_q;
    fpc_d          = fpc_q;
    target_d       = target_q;

    // Request is gated by rst so imem_req reads 0 while reset is held.
    unique case (state_q)
      IDLE:        imem.imem_req = rst && (count_q < CW'(DEPTH));
      WAIT, DRAIN: imem.imem_req = 1'b1;
      default:     imem.imem_req = 1'b0;
    endcase

    ack_hit = imem.imem_ack && imem.imem_req;
    accept  = ack_hit && (state_q != DRAIN) && !redirect;

    if (redirect) begin
      // A request the memory already holds must finish; park the target until its ack.
      if (state_q == DRAIN) begin
        if (ack_hit) begin
          fpc_d   = redirect_pc;
          state_d = IDLE;
        end else begin
          target_d = redirect_pc;
        end
      end else if (imem.imem_req && !imem.imem_ack) begin
        target_d = redirect_pc;
        state_d  = DRAIN;
      end else begin
        fpc_d   = redirect_pc;
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (imem.imem_req) begin
            if (imem.imem_ack) fpc_d = fpc_inc;
            else               state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_ack) begin
            fpc_d   = fpc_inc;
            state_d = IDLE;
          end
        end
        DRAIN: begin
          if (imem.imem_ack) begin
            fpc_d   = target_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = accept && !fifo_valid;
  assign wr_en  = accept && !(bypass && deq);
`else
  assign wr_en  = accept;
`endif
  assign rd_en = deq && !redirect && fifo_valid;

  always_comb begin
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc4   = '0;
    if (fifo_valid) begin
      inst_valid = 1'b1;
      inst       = inst_mem[rptr_q];
      inst_pc4   = pc4_mem[rptr_q];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass) begin
      inst_valid = 1'b1;
      inst       = imem.imem_rdata;
      inst_pc4   = fpc_inc;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_PC;
      target_q <= RESET_PC;
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      target_q <= target_d;
      if (redirect) begin
        rptr_q  <= '0;
        wptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (wr_en) wptr_q <= wptr_q + PW'(1);
        if (rd_en) rptr_q <= rptr_q + PW'(1);
        unique case ({wr_en, rd_en})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem[wptr_q] <= imem.imem_rdata;
      pc4_mem[wptr_q]  <= fpc_inc;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue that sits directly upstream of the IF/ID stage register. It owns the fetch PC and issues one-at-a-time requests to a variable-latency instruction memory. Returned words are buffered with their PC+4 in a small FIFO, and the pipeline dequeues one instruction per cycle. A redirect (branch, jump or jr target) flushes the queue and restarts fetch.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0: fetch PC after reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; word aligned.
- deq  in  1  pipeline consumes head entry (IF/ID load enable).
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address.
- imem_ack  in  1  response valid; may coincide with imem_req.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- inst_valid  out  1  head entry valid.
- inst  out  32  head instruction; 32'h0 (NOP) when inst_valid=0.
- inst_pc4  out  32  PC+4 of head instruction; 32'h0 when inst_valid=0.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- State:
  - fetch PC `fpc`
  - FIFO of {pc4, inst} with read pointer, write pointer and count
  - FSM with states IDLE, WAIT and DRAIN
- IDLE:
  - When count + (pending deq-free slot) < DEPTH, i.e. count < DEPTH, assert imem_req with imem_addr=fpc and go to WAIT.
  - If imem_ack arrives in the same cycle, handle it as in WAIT and stay in IDLE.
- WAIT:
  - Hold imem_req=1 and imem_addr stable until imem_ack.
  - On ack, write {fpc+4, imem_rdata}, set fpc ← fpc+4, and return to IDLE.
- DRAIN:
  - Entered on redirect while a request is unacknowledged. The request cannot be aborted: imem_req stays high with the old address.
  - On ack, discard the response, set fpc ← latched redirect target, and go to IDLE.
- Redirect (highest priority):
  - Clears count and both pointers in the same edge.
  - Same-cycle deq is ignored. A same-cycle ack that is not already draining is discarded.
  - With no outstanding request: fpc ← redirect_pc, go to IDLE.
  - Redirect while in DRAIN: overwrite the latched target and stay in DRAIN.
- deq:
  - With inst_valid=1, advance the read pointer and decrement count.
  - deq while empty is ignored.
- Simultaneous ack and deq: count stays unchanged and data is written and read in separate entries.
- Full (count=DEPTH): no new request is issued. An in-flight ack is still accepted because requests are only issued when count<DEPTH and only one is ever outstanding.
- PC arithmetic is modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - inst_valid=0, inst=0, inst_pc4=0, count=0
  - fpc=RESET_PC, FSM=IDLE
- imem_req asserts in the first cycle after rst deasserts.
- Latency from ack to inst_valid is 1 cycle: the entry is visible on the edge after the ack.
- Sustained throughput is 1 instruction/cycle when memory acks in the same cycle as the request.
- Redirect at edge N:
  - inst_valid=0 after edge N.
  - First request at redirect_pc goes out in cycle N+1, or in the cycle after the draining ack.
- Reset mid-operation: everything returns to reset values immediately. An outstanding memory transaction is abandoned, and the memory must tolerate this.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When the FIFO is empty and imem_ack=1 (not draining, no redirect), imem_rdata and fpc+4 drive inst and inst_pc4 combinationally, with inst_valid=1 in the same cycle.
  - If deq is also 1, the word is consumed and not written to the FIFO.
  - Ack-to-inst_valid latency becomes 0.
- FETCH_QUEUE_BYPASS_EN undefined: outputs come only from FIFO registers, with 1-cycle latency and no combinational path from imem to inst.

## Test plan
- Reset release with RESET_PC=0 and memory acking every request in the same cycle, deq=0 → addresses 0, 4, 8, 12 fetched; count reaches 4, imem_req drops, head inst=mem[0], inst_pc4=4.
- Full queue, then deq held 1 for 3 cycles → heads mem[0], mem[4], mem[8] in order; one new request issued per freed slot; count never exceeds 4.
- Redirect to 32'h100 while count=3 and no request pending → next cycle count=0, inst_valid=0, inst=0; imem_addr=32'h100 and imem_req=1.
- Request at 32'h8 with ack delayed 3 cycles, redirect to 32'h40 in the 2nd wait cycle → imem_addr stays 8 until the ack; the response is dropped (count stays 0); the next request is at 32'h40.
- fpc=32'hFFFFFFFC, ack → entry has inst_pc4=0; next imem_addr=0.
- With FETCH_QUEUE_BYPASS_EN: empty queue, ack with rdata=32'h20010005 and deq=1 in the same cycle → inst=32'h20010005 and inst_valid=1 that cycle; count stays 0.
